// File: rtl/player_motion_ctrl_pkg.sv
// Shared game definitions for the player motion controller: directions, FSM
// states, screen/tile geometry and helpers for the packed {x, y} position bus.
package player_motion_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int TILE_SHIFT = 5;
  localparam int SPRITE     = 16;
  localparam int POS_W      = 10;
  localparam int TILE_W     = 6;

  function automatic logic [2*POS_W-1:0] pos_pack(input logic [POS_W-1:0] x,
                                                  input logic [POS_W-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [POS_W-1:0] pos_x(input logic [2*POS_W-1:0] p);
    return p[2*POS_W-1:POS_W];
  endfunction

  function automatic logic [POS_W-1:0] pos_y(input logic [2*POS_W-1:0] p);
    return p[POS_W-1:0];
  endfunction

  // Pixel coordinate to tile-map coordinate.
  function automatic logic [TILE_W-1:0] tile_of(input logic [POS_W-1:0] px);
    logic [POS_W-1:0] t;
    t = px >> TILE_SHIFT;
    return t[TILE_W-1:0];
  endfunction

endpackage

// File: rtl/player_motion_ctrl_target_calc.sv
// Combinational target position for one frame: button step or knockback, clamped
// to the playfield. Optional diagonal movement under PLAYER_DIAGONAL_EN.
module player_target_calc
  import player_motion_ctrl_pkg::*;
#(
  parameter int STEP  = 2,
  parameter int KNOCK = 8,
  parameter int MAX_X = 624,
  parameter int MAX_Y = 464
) (
  input  logic [POS_W-1:0] pos_x_i,
  input  logic [POS_W-1:0] pos_y_i,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             kb,
  input  dir_e             last_dir,
  output logic [POS_W-1:0] tgt_x,
  output logic [POS_W-1:0] tgt_y,
  output dir_e             new_dir,
  output logic             active
);

  localparam logic signed [POS_W:0] MAX_X_S = (POS_W+1)'(MAX_X);
  localparam logic signed [POS_W:0] MAX_Y_S = (POS_W+1)'(MAX_Y);
  localparam logic signed [POS_W:0] STEP_S  = (POS_W+1)'(STEP);
  localparam logic signed [POS_W:0] KNOCK_S = (POS_W+1)'(KNOCK);

  logic up_n, down_n, left_n, right_n;
  logic signed [POS_W:0] dx, dy, sx, sy;

  // Opposing buttons cancel before any priority is applied.
  assign up_n    = btn_up & ~btn_down;
  assign down_n  = btn_down & ~btn_up;
  assign left_n  = btn_left & ~btn_right;
  assign right_n = btn_right & ~btn_left;

  always_comb begin
    dx      = '0;
    dy      = '0;
    new_dir = last_dir;
    active  = 1'b0;
    if (kb) begin
      active = 1'b1;
      case (last_dir)
        DIR_UP:    dy = KNOCK_S;
        DIR_DOWN:  dy = -KNOCK_S;
        DIR_LEFT:  dx = KNOCK_S;
        default:   dx = -KNOCK_S;
      endcase
    end else begin
      active = up_n | down_n | left_n | right_n;
`ifdef PLAYER_DIAGONAL_EN
      if (up_n)        dy = -STEP_S;
      else if (down_n) dy = STEP_S;
      if (left_n)       dx = -STEP_S;
      else if (right_n) dx = STEP_S;
      if (up_n)         new_dir = DIR_UP;
      else if (down_n)  new_dir = DIR_DOWN;
      else if (left_n)  new_dir = DIR_LEFT;
      else if (right_n) new_dir = DIR_RIGHT;
`else
      if (up_n) begin
        dy = -STEP_S;  new_dir = DIR_UP;
      end else if (down_n) begin
        dy = STEP_S;   new_dir = DIR_DOWN;
      end else if (left_n) begin
        dx = -STEP_S;  new_dir = DIR_LEFT;
      end else if (right_n) begin
        dx = STEP_S;   new_dir = DIR_RIGHT;
      end
`endif
    end
  end

  assign sx = $signed({1'b0, pos_x_i}) + dx;
  assign sy = $signed({1'b0, pos_y_i}) + dy;

  always_comb begin
    tgt_x = sx[POS_W-1:0];
    tgt_y = sy[POS_W-1:0];
    if (sx < 0)            tgt_x = '0;
    else if (sx > MAX_X_S) tgt_x = POS_W'(MAX_X);
    if (sy < 0)            tgt_y = '0;
    else if (sy > MAX_Y_S) tgt_y = POS_W'(MAX_Y);
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player motion controller: per-frame move/knockback target, four-corner tile
// wall check over a req/ack handshake, then commit. Option: PLAYER_DIAGONAL_EN.
module player_motion_ctrl
  import player_motion_ctrl_pkg::*;
#(
  parameter int STEP          = 2,
  parameter int KNOCK         = 8,
  parameter int MAX_X         = SCREEN_W - SPRITE,
  parameter int MAX_Y         = SCREEN_H - SPRITE,
  parameter int START_X       = 32,
  parameter int START_Y       = 32,
  parameter int INVULN_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 enemy_collide,
  input  logic                 tile_ack,
  input  logic                 tile_wall,
  output logic                 tile_req,
  output logic [TILE_W-1:0]    tile_x,
  output logic [TILE_W-1:0]    tile_y,
  output logic [2*POS_W-1:0]   position,
  output logic                 moving,
  output logic                 hit_pulse,
  output logic                 invuln
);

  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

  state_e            state_q, state_d;
  dir_e              last_dir_q, last_dir_d;
  logic [POS_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [POS_W-1:0]  tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [1:0]        corner_q, corner_d;
  logic              tile_req_q, tile_req_d;
  logic [TILE_W-1:0] tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic              moving_q, moving_d, hit_pulse_q, hit_pulse_d, kb_q, kb_d;
  logic [CNT_W-1:0]  invuln_q, invuln_d;

  logic              hit_now, calc_active;
  logic [POS_W-1:0]  calc_x, calc_y;
  dir_e              calc_dir;
  logic [1:0]        corner_nx;
  logic [TILE_W-1:0] corner_tx [4];
  logic [TILE_W-1:0] corner_ty [4];

  assign hit_now = (state_q == ST_IDLE) && frame_tick && enemy_collide && (invuln_q == '0);

  player_target_calc #(
    .STEP (STEP),
    .KNOCK(KNOCK),
    .MAX_X(MAX_X),
    .MAX_Y(MAX_Y)
  ) u_target_calc (
    .pos_x_i  (pos_x_q),
    .pos_y_i  (pos_y_q),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .kb       (hit_now),
    .last_dir (last_dir_q),
    .tgt_x    (calc_x),
    .tgt_y    (calc_y),
    .new_dir  (calc_dir),
    .active   (calc_active)
  );

  // Corner k: bit 0 selects the right edge, bit 1 the bottom edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_corner
      localparam logic [POS_W-1:0] OFF_X = (gi % 2 == 1) ? POS_W'(SPRITE - 1) : '0;
      localparam logic [POS_W-1:0] OFF_Y = (gi >= 2) ? POS_W'(SPRITE - 1) : '0;
      assign corner_tx[gi] = tile_of(tgt_x_q + OFF_X);
      assign corner_ty[gi] = tile_of(tgt_y_q + OFF_Y);
    end
  endgenerate

  assign corner_nx = corner_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    corner_d    = corner_q;
    tile_req_d  = tile_req_q;
    tile_x_d    = tile_x_q;
    tile_y_d    = tile_y_q;
    moving_d    = moving_q;
    kb_d        = kb_q;
    hit_pulse_d = 1'b0;
    invuln_d    = invuln_q;

    if (frame_tick && (invuln_q != '0)) invuln_d = invuln_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          if (hit_now) begin
            invuln_d    = CNT_W'(INVULN_FRAMES);
            hit_pulse_d = 1'b1;
            kb_d        = 1'b1;
          end
          if (calc_active) begin
            last_dir_d = calc_dir;
            if ((calc_x == pos_x_q) && (calc_y == pos_y_q)) begin
              moving_d = 1'b0;
              kb_d     = 1'b0;
            end else begin
              tgt_x_d    = calc_x;
              tgt_y_d    = calc_y;
              corner_d   = 2'd0;
              tile_req_d = 1'b1;
              tile_x_d   = tile_of(calc_x);
              tile_y_d   = tile_of(calc_y);
              state_d    = ST_CHECK;
            end
          end else begin
            moving_d = 1'b0;
          end
        end
      end

      ST_CHECK: begin
        if (!tile_req_q) begin
          // Gap cycle after an ack: coordinates already point at the next corner.
          tile_req_d = 1'b1;
        end else if (tile_ack) begin
          tile_req_d = 1'b0;
          if (tile_wall) begin
            moving_d = 1'b0;
            kb_d     = 1'b0;
            state_d  = ST_IDLE;
          end else if (corner_q == 2'd3) begin
            state_d = ST_COMMIT;
          end else begin
            corner_d = corner_nx;
            tile_x_d = corner_tx[corner_nx];
            tile_y_d = corner_ty[corner_nx];
          end
        end
      end

      ST_COMMIT: begin
        pos_x_d  = tgt_x_q;
        pos_y_d  = tgt_y_q;
        moving_d = ~kb_q;
        kb_d     = 1'b0;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_dir_q  <= DIR_DOWN;
      pos_x_q     <= POS_W'(START_X);
      pos_y_q     <= POS_W'(START_Y);
      tgt_x_q     <= POS_W'(START_X);
      tgt_y_q     <= POS_W'(START_Y);
      corner_q    <= 2'd0;
      tile_req_q  <= 1'b0;
      tile_x_q    <= '0;
      tile_y_q    <= '0;
      moving_q    <= 1'b0;
      hit_pulse_q <= 1'b0;
      kb_q        <= 1'b0;
      invuln_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      corner_q    <= corner_d;
      tile_req_q  <= tile_req_d;
      tile_x_q    <= tile_x_d;
      tile_y_q    <= tile_y_d;
      moving_q    <= moving_d;
      hit_pulse_q <= hit_pulse_d;
      kb_q        <= kb_d;
      invuln_q    <= invuln_d;
    end
  end

  assign tile_req  = tile_req_q;
  assign tile_x    = tile_x_q;
  assign tile_y    = tile_y_q;
  assign position  = pos_pack(pos_x_q, pos_y_q);
  assign moving    = moving_q;
  assign hit_pulse = hit_pulse_q;
  assign invuln    = (invuln_q != '0);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: moves, clamping, wall abort, knockback,
// invulnerability countdown, async reset mid-check, diagonal option.
module tb_player_motion_ctrl;
  import player_motion_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        enemy_collide = 1'b0;
  logic        tile_ack = 1'b0, tile_wall = 1'b0;
  logic        tile_req;
  logic [5:0]  tile_x, tile_y;
  logic [19:0] position;
  logic        moving, hit_pulse, invuln;

  int n_checks = 0;
  int n_fail   = 0;
  int hp_count = 0;
  int exp_x, exp_y, nreq, hp0;
  logic [5:0] seen_tx [4];
  logic [5:0] seen_ty [4];

  player_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .enemy_collide(enemy_collide), .tile_ack(tile_ack), .tile_wall(tile_wall),
    .tile_req(tile_req), .tile_x(tile_x), .tile_y(tile_y), .position(position),
    .moving(moving), .hit_pulse(hit_pulse), .invuln(invuln)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (hit_pulse) hp_count <= hp_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  // Acknowledge tile requests; corner index wall_k reports a wall (-1: none).
  task automatic service(input int wall_k, output int n);
    int idle;
    n = 0;
    idle = 0;
    while (n < 4 && idle < 6) begin
      if (tile_req) begin
        seen_tx[n] = tile_x;
        seen_ty[n] = tile_y;
        tile_ack  = 1'b1;
        tile_wall = (n == wall_k);
        @(posedge clk); #1;
        tile_ack  = 1'b0;
        tile_wall = 1'b0;
        n++;
        idle = 0;
        if (n - 1 == wall_k) break;
      end else begin
        @(posedge clk); #1;
        idle++;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int wall_k, output int n);
    pulse_tick();
    service(wall_k, n);
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right; tiles never walls.
  task automatic walk(input int dir, input int frames);
    int n;
    btn_up = (dir == 0); btn_down = (dir == 1); btn_left = (dir == 2); btn_right = (dir == 3);
    for (int i = 0; i < frames; i++) frame(-1, n);
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    case (dir)
      0: exp_y -= 2 * frames;
      1: exp_y += 2 * frames;
      2: exp_x -= 2 * frames;
      default: exp_x += 2 * frames;
    endcase
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_pos", position, {10'd32, 10'd32});
    check("reset_req", tile_req, 0);
    check("reset_moving", moving, 0);
    check("reset_hit", hit_pulse, 0);
    check("reset_invuln", invuln, 0);
    rst = 1'b0;
    exp_x = 32; exp_y = 32;

    // Move right once: corners (34,32),(49,32),(34,47),(49,47) all in tile (1,1).
    btn_right = 1'b1;
    frame(-1, nreq);
    btn_right = 1'b0;
    exp_x = 34;
    check("t1_nreq", nreq, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_tile_x%0d", k), seen_tx[k], 1);
      check($sformatf("t1_tile_y%0d", k), seen_ty[k], 1);
    end
    check("t1_pos", position, {10'd34, 10'd32});
    check("t1_moving", moving, 1);

    // Stray ack while idle has no effect.
    tile_ack = 1'b1; tile_wall = 1'b1;
    @(posedge clk); #1;
    tile_ack = 1'b0; tile_wall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stray_ack_req", tile_req, 0);
    check("stray_ack_pos", position, {10'd34, 10'd32});

    // Wall on corner 1: (77,32) -> tile (2,1); move aborted.
    walk(3, 13);
    check("t3_start", position, {10'd60, 10'd32});
    btn_right = 1'b1;
    frame(1, nreq);
    btn_right = 1'b0;
    check("t3_nreq", nreq, 2);
    check("t3_tile_x1", seen_tx[1], 2);
    check("t3_tile_y1", seen_ty[1], 1);
    check("t3_pos", position, {10'd60, 10'd32});
    check("t3_moving", moving, 0);
    check("t3_req", tile_req, 0);

    // Knockback from (100,100) facing right.
    walk(1, 34);
    walk(3, 20);
    check("t4_start", position, {10'd100, 10'd100});
    enemy_collide = 1'b1;
    hp0 = hp_count;
    pulse_tick();
    check("t4_hit_pulse", hit_pulse, 1);
    service(-1, nreq);
    check("t4_nreq", nreq, 4);
    check("t4_pos", position, {10'd92, 10'd100});
    check("t4_invuln", invuln, 1);
    check("t4_moving", moving, 0);
    check("t4_hp_count", hp_count - hp0, 1);
    frame(-1, nreq);
    enemy_collide = 1'b0;
    check("t4_ignored_nreq", nreq, 0);
    check("t4_ignored_pos", position, {10'd92, 10'd100});
    check("t4_ignored_hp", hp_count - hp0, 1);
    for (int i = 0; i < 28; i++) pulse_tick();
    #1;
    check("t4_invuln_last", invuln, 1);
    pulse_tick();
    #1;
    check("t4_invuln_done", invuln, 0);
    exp_x = 92; exp_y = 100;

    // Up + right from (100,100).
    walk(3, 4);
    btn_up = 1'b1; btn_right = 1'b1;
    frame(-1, nreq);
    btn_up = 1'b0; btn_right = 1'b0;
    check("t6_nreq", nreq, 4);
`ifdef PLAYER_DIAGONAL_EN
    exp_x = 102; exp_y = 98;
`else
    exp_x = 100; exp_y = 98;
`endif
    check("t6_pos", position, {exp_x[9:0], exp_y[9:0]});

    // Clamp at left edge: target equals position -> no requests.
    walk(2, exp_x / 2);
    walk(1, (100 - exp_y) / 2);
    check("t2_start", position, {10'd0, 10'd100});
    check("t2_moving_before", moving, 1);
    btn_left = 1'b1;
    frame(-1, nreq);
    btn_left = 1'b0;
    check("t2_nreq", nreq, 0);
    check("t2_moving", moving, 0);
    check("t2_pos", position, {10'd0, 10'd100});

    // Async reset during a check.
    btn_right = 1'b1;
    pulse_tick();
    check("t5_req_before", tile_req, 1);
    rst = 1'b1;
    #1;
    check("t5_req_async", tile_req, 0);
    check("t5_pos_async", position, {10'd32, 10'd32});
    @(posedge clk); #1;
    rst = 1'b0;
    frame(-1, nreq);
    btn_right = 1'b0;
    check("t5_after_nreq", nreq, 4);
    check("t5_after_pos", position, {10'd34, 10'd32});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
